// File: rtl/uart_tx_cfg_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg_if
// Description : Host-side handshake bundle for the configurable UART
//               transmitter: start request, payload, parity mode and the
//               ready/done/parity status returned to the host.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_cfg_if #(
  parameter int DBIT = 8
);
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic [1:0]      parity_mode;
  logic            tx_ready;
  logic            tx_done_tick;
  logic            tx_parity;

  // Byte source side
  modport master (
    output tx_start,
    output din,
    output parity_mode,
    input  tx_ready,
    input  tx_done_tick,
    input  tx_parity
  );

  // Transmitter side
  modport slave (
    input  tx_start,
    input  din,
    input  parity_mode,
    output tx_ready,
    output tx_done_tick,
    output tx_parity
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : Parametrised UART transmitter. DBIT data bits LSB first,
//               run-time parity (none/even/odd/mark) latched per frame,
//               OS_TICK oversample ticks per bit and SB_TICK ticks of stop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
  parameter int DBIT    = 8,
  parameter int OS_TICK = 16,
  parameter int SB_TICK = 16
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  input  wire logic       s_tick_i,
  uart_tx_cfg_if.slave    host_if,
  output logic            tx_o
);

  localparam int TMAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = $clog2(DBIT);

  localparam logic [TW-1:0] C_OS_LAST  = TW'(OS_TICK - 1);
  localparam logic [TW-1:0] C_SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] C_BIT_LAST = BW'(DBIT - 1);

  localparam logic [1:0] C_PM_NONE = 2'b00;
  localparam logic [1:0] C_PM_EVEN = 2'b01;
  localparam logic [1:0] C_PM_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   tick_q;
  logic [BW-1:0]   bit_q;
  logic [DBIT-1:0] shreg_q;
  logic [1:0]      mode_q;
  logic            parity_q;
  logic            tx_q;
  logic            ready_q;
  logic            done_q;

  logic            parity_d;
  logic            tick_end;

  // Parity bit for the word being offered; only registered on acceptance
  always_comb begin
    parity_d = 1'b0;
    case (host_if.parity_mode)
      C_PM_EVEN: parity_d = ^host_if.din;
      C_PM_ODD:  parity_d = ~(^host_if.din);
      C_PM_NONE: parity_d = 1'b0;
      default:   parity_d = 1'b1;
    endcase
  end

  // Last oversample tick of the current bit (stop period uses its own length)
  always_comb begin
    tick_end = 1'b0;
    if (s_tick_i) begin
      tick_end = (state_q == ST_STOP) ? (tick_q == C_SB_LAST)
                                      : (tick_q == C_OS_LAST);
    end
  end

  // Frame sequencer: all outputs are registered on the bit-boundary edge.
  // ready is held low through the done cycle so a start there is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      mode_q   <= C_PM_NONE;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (!ready_q) begin
            ready_q <= 1'b1;
          end else if (host_if.tx_start) begin
            shreg_q  <= host_if.din;
            mode_q   <= host_if.parity_mode;
            parity_q <= parity_d;
            tick_q   <= '0;
            tx_q     <= 1'b0;
            ready_q  <= 1'b0;
            state_q  <= ST_START;
          end
        end

        ST_START: begin
          if (tick_end) begin
            tick_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shreg_q[0];
            state_q <= ST_DATA;
          end else if (s_tick_i) begin
            tick_q <= tick_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (tick_end) begin
            tick_q  <= '0;
            shreg_q <= {1'b0, shreg_q[DBIT-1:1]};
            if (bit_q == C_BIT_LAST) begin
              if (mode_q == C_PM_NONE) begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end else begin
                tx_q    <= parity_q;
                state_q <= ST_PARITY;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= shreg_q[1];
            end
          end else if (s_tick_i) begin
            tick_q <= tick_q + 1'b1;
          end
        end

        ST_PARITY: begin
          if (tick_end) begin
            tick_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end else if (s_tick_i) begin
            tick_q <= tick_q + 1'b1;
          end
        end

        ST_STOP: begin
          tx_q <= 1'b1;
          if (tick_end) begin
            tick_q  <= '0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (s_tick_i) begin
            tick_q <= tick_q + 1'b1;
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          tick_q   <= '0;
          bit_q    <= '0;
          shreg_q  <= '0;
          mode_q   <= C_PM_NONE;
          parity_q <= 1'b0;
          tx_q     <= 1'b1;
          ready_q  <= 1'b1;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_o                 = tx_q;
  assign host_if.tx_ready     = ready_q;
  assign host_if.tx_done_tick = done_q;
  assign host_if.tx_parity    = parity_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Directed self-checking bench for uart_tx_cfg. Expected line
//               bits are queued when a frame is offered and popped at the
//               middle of each bit; frame length, ready, done and parity
//               status are checked against a bench-side model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

  logic clk;
  logic reset_n;
  logic s_tick;
  logic tx_a;
  logic tx_b;

  uart_tx_cfg_if #(.DBIT(8)) if_a ();
  uart_tx_cfg_if #(.DBIT(7)) if_b ();

  uart_tx_cfg #(.DBIT(8), .OS_TICK(16), .SB_TICK(16)) dut_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_tick_i (s_tick),
    .host_if  (if_a.slave),
    .tx_o     (tx_a)
  );

  uart_tx_cfg #(.DBIT(7), .OS_TICK(16), .SB_TICK(32)) dut_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_tick_i (s_tick),
    .host_if  (if_b.slave),
    .tx_o     (tx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors;
  int   miscompares;
  logic sel;
  logic exp_q[$];
  logic exp_arr[16];

  wire obs_tx     = sel ? tx_b              : tx_a;
  wire obs_ready  = sel ? if_b.tx_ready     : if_a.tx_ready;
  wire obs_done   = sel ? if_b.tx_done_tick : if_a.tx_done_tick;
  wire obs_parity = sel ? if_b.tx_parity    : if_a.tx_parity;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic s, input logic st, input logic [8:0] d, input logic [1:0] m);
    if (!s) begin
      if_a.tx_start = st; if_a.din = d[7:0]; if_a.parity_mode = m;
    end else begin
      if_b.tx_start = st; if_b.din = d[6:0]; if_b.parity_mode = m;
    end
  endtask

  function automatic logic model_parity(input logic [8:0] d, input logic [1:0] m, input int dbit);
    logic x;
    x = 1'b0;
    for (int i = 0; i < dbit; i++) x = x ^ d[i];
    case (m)
      2'b00:   return 1'b0;
      2'b01:   return x;
      2'b10:   return ~x;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int spot(input int k, input int nb, input int sb);
    return (k < nb - 1) ? (k * 16 + 8) : (k * 16 + sb / 2);
  endfunction

  // One frame: queue the expected line, offer it, then follow the line
  // tick by tick. Optional: stray start at inject_at, 100-clk tick stall at
  // stall_at, asynchronous reset at reset_at (tick counts from acceptance).
  task automatic run_frame(input logic s, input logic [8:0] d, input logic [1:0] m,
                           input int inject_at, input int stall_at, input int reset_at);
    int   dbit, sb, nbits, total, ticks, k, dones;
    logic par, fin, aborted, stalled;
    dbit = s ? 7 : 8;
    sb   = s ? 32 : 16;
    par  = model_parity(d, m, dbit);
    exp_q.delete();
    nbits = 0;
    exp_q.push_back(1'b0); exp_arr[nbits++] = 1'b0;
    for (int i = 0; i < dbit; i++) begin
      exp_q.push_back(d[i]); exp_arr[nbits++] = d[i];
    end
    if (m != 2'b00) begin
      exp_q.push_back(par); exp_arr[nbits++] = par;
    end
    exp_q.push_back(1'b1); exp_arr[nbits++] = 1'b1;
    total = 16 * (1 + dbit) + ((m != 2'b00) ? 16 : 0) + sb;

    sel = s;
    s_tick = 1'b0;
    @(negedge clk);
    chk("ready_idle", obs_ready, 1);
    chk("tx_idle", obs_tx, 1);
    set_in(s, 1'b1, d, m);
    @(negedge clk);
    set_in(s, 1'b0, ~d, ~m);
    chk("parity_latched", obs_parity, par);
    chk("ready_accepted", obs_ready, 0);

    ticks = 0; k = 0; dones = 0;
    fin = 1'b0; aborted = 1'b0; stalled = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      s_tick = (cyc % 2 == 0);
      if (inject_at >= 0 && ticks >= inject_at && ticks < inject_at + 3)
        set_in(s, 1'b1, 9'h1FF, 2'b01);
      else
        set_in(s, 1'b0, ~d, 2'(cyc));
      @(negedge clk);
      if (s_tick) ticks++;

      if (k < nbits && ticks == spot(k, nbits, sb)) begin
        chk($sformatf("bit%0d", k), obs_tx, exp_q.pop_front());
        k++;
      end

      if (stall_at >= 0 && !stalled && ticks == stall_at) begin
        stalled = 1'b1;
        s_tick = 1'b0;
        repeat (100) @(negedge clk);
        chk("stall_tx", obs_tx, exp_arr[ticks / 16]);
        chk("stall_ready", obs_ready, 0);
        chk("stall_done", obs_done, 0);
      end

      if (reset_at >= 0 && ticks == reset_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_tx", obs_tx, 1);
        chk("rst_ready", obs_ready, 1);
        chk("rst_done", obs_done, 0);
        chk("rst_parity", obs_parity, 0);
        s_tick = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("rst_no_done", obs_done, 0);
        end
        reset_n = 1'b1;
        aborted = 1'b1;
        exp_q.delete();
        fin = 1'b1;
      end else if (obs_done) begin
        dones++;
        chk("frame_ticks", ticks, total);
        chk("ready_in_done", obs_ready, 0);
        chk("parity_hold", obs_parity, par);
        if (inject_at >= 0) set_in(s, 1'b1, 9'h1FF, 2'b01);
        s_tick = 1'b0;
        @(negedge clk);
        set_in(s, 1'b0, d, m);
        chk("ready_after_done", obs_ready, 1);
        chk("done_single", obs_done, 0);
        chk("tx_after_done", obs_tx, 1);
        fin = 1'b1;
      end else begin
        chk("ready_busy", obs_ready, 0);
      end
    end
    if (!aborted) begin
      chk("done_count", dones, 1);
      chk("bits_left", exp_q.size(), 0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    sel         = 1'b0;
    s_tick      = 1'b0;
    reset_n     = 1'b0;
    set_in(1'b0, 1'b0, 9'h0, 2'b00);
    set_in(1'b1, 1'b0, 9'h0, 2'b00);
    repeat (3) @(negedge clk);
    chk("reset_tx_a", tx_a, 1);
    chk("reset_ready_a", if_a.tx_ready, 1);
    chk("reset_done_a", if_a.tx_done_tick, 0);
    chk("reset_parity_a", if_a.tx_parity, 0);
    chk("reset_tx_b", tx_b, 1);
    chk("reset_ready_b", if_b.tx_ready, 1);
    reset_n = 1'b1;
    @(negedge clk);

    // Defaults, 0x55 even parity
    run_frame(1'b0, 9'h055, 2'b01, -1, -1, -1);
    // 0xA7 under every parity mode
    run_frame(1'b0, 9'h0A7, 2'b01, -1, -1, -1);
    run_frame(1'b0, 9'h0A7, 2'b10, -1, -1, -1);
    run_frame(1'b0, 9'h0A7, 2'b11, -1, -1, -1);
    run_frame(1'b0, 9'h0A7, 2'b00, -1, -1, -1);
    // Stray start mid-frame and in the done cycle
    run_frame(1'b0, 9'h012, 2'b01, 40, -1, -1);
    // Reset halfway through data bit 3, then a clean frame
    run_frame(1'b0, 9'h03C, 2'b01, -1, -1, 72);
    run_frame(1'b0, 9'h03C, 2'b10, -1, -1, -1);
    // Tick stall inside the data phase
    run_frame(1'b0, 9'h096, 2'b01, -1, 84, -1);
    // 7 data bits, 2 stop bits, odd parity
    run_frame(1'b1, 9'h041, 2'b10, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
